// File: rtl/wb_timer16_pkg.sv
// Shared register map and CTRL/STAT bit positions for the 16-bit Wishbone timer.
// Firmware headers mirror these values, so keep them in sync when editing.
package timer_pkg;

  // Register addresses
  typedef enum logic [2:0] {
    ADR_CNT_L = 3'd0,
    ADR_CNT_H = 3'd1,
    ADR_CMP_L = 3'd2,
    ADR_CMP_H = 3'd3,
    ADR_CTRL  = 3'd4,
    ADR_STAT  = 3'd5,
    ADR_RSV6  = 3'd6,
    ADR_RSV7  = 3'd7
  } reg_adr_e;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_CMPIE = 1;
  localparam int CTRL_CTC   = 2;
  localparam int CTRL_OVFIE = 3;

  // STAT bit positions
  localparam int STAT_CMPF = 0;
  localparam int STAT_OVF  = 1;

  // CTRL register image; field order matches the bit positions above
  typedef struct packed {
    logic ovfie;
    logic ctc;
    logic cmpie;
    logic en;
  } ctrl_t;

  // CTRL as seen on the bus: upper nibble always reads 0
  function automatic logic [7:0] ctrl_rd(ctrl_t c);
    return {4'h0, c};
  endfunction

endpackage

// File: rtl/wb_timer16_if.sv
// Wishbone slave bus plus interrupt request/acknowledge for the timer.
interface wb_timer16_if;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i;
  logic       wb_stb_i;
  logic       wb_ack_o;
  logic [1:0] irq_o;
  logic [1:0] irq_ack_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, irq_ack_i,
    output wb_dat_o, wb_ack_o, irq_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, irq_ack_i,
    input  wb_dat_o, wb_ack_o, irq_o
  );
endinterface

// File: rtl/wb_timer16_presc.sv
// Prescaler: counts 0..PRESC-1 while enabled, one-cycle tick at PRESC-1.
module timer_presc #(
  parameter int PRESC = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);
  localparam logic [15:0] LAST = 16'(PRESC - 1);

  logic [15:0] pcnt;

  // Divider count; parked at 0 while disabled so a re-enable starts a full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pcnt <= '0;
    else if (!ena)         pcnt <= '0;
    else if (pcnt == LAST) pcnt <= '0;
    else                   pcnt <= pcnt + 16'd1;
  end

  assign tick = ena && (pcnt == LAST);

endmodule

// File: rtl/wb_timer16.sv
// 16-bit timer with compare/clear-on-match and overflow interrupts behind an
// 8-bit zero-wait-state Wishbone slave. 16-bit values go through a shared TEMP
// byte so the CPU sees coherent counter reads and atomic counter/compare writes.
module wb_timer16
  import timer_pkg::*;
#(
  parameter int PRESC       = 24,
  parameter int ENA_OVF_IRQ = 1
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  wb_timer16_if.slave  bus
);

  logic [15:0] cnt, cmp;
  logic [7:0]  temp;
  ctrl_t       ctrl;
  logic        cmpf, ovf;
  logic        tick;

  reg_adr_e    adr;
  logic        wr, rd;
  logic        wr_cnt_l, wr_cnt_h, wr_cmp_l, wr_cmp_h, wr_ctrl, wr_stat, rd_cnt_l;
  logic        match, tick_clr, wrap, hw_cmpf, hw_ovf, clr_cmpf, clr_ovf;

  timer_presc #(.PRESC(PRESC)) u_presc (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .ena  (ctrl.en),
    .tick (tick)
  );

  // Bus decode
  assign adr      = reg_adr_e'(bus.wb_adr_i);
  assign wr       = bus.wb_stb_i &  bus.wb_we_i;
  assign rd       = bus.wb_stb_i & ~bus.wb_we_i;
  assign wr_cnt_l = wr && (adr == ADR_CNT_L);
  assign wr_cnt_h = wr && (adr == ADR_CNT_H);
  assign wr_cmp_l = wr && (adr == ADR_CMP_L);
  assign wr_cmp_h = wr && (adr == ADR_CMP_H);
  assign wr_ctrl  = wr && (adr == ADR_CTRL);
  assign wr_stat  = wr && (adr == ADR_STAT);
  assign rd_cnt_l = rd && (adr == ADR_CNT_L);
  assign bus.wb_ack_o = bus.wb_stb_i;

  // Tick outcome. A software CNT_L write on the same edge replaces the whole
  // tick effect, including any flag it would have raised.
  assign match    = (cnt == cmp);
  assign tick_clr = tick && match && ctrl.ctc;
  assign wrap     = tick && !tick_clr && (cnt == 16'hFFFF);
  assign hw_cmpf  = tick && match && !wr_cnt_l;
  assign hw_ovf   = wrap && !wr_cnt_l;
  assign clr_cmpf = (wr_stat && bus.wb_dat_i[STAT_CMPF]) || bus.irq_ack_i[0];
  assign clr_ovf  = (wr_stat && bus.wb_dat_i[STAT_OVF])  || bus.irq_ack_i[1];

  // Counter: software load beats tick; tick either clears on match or increments
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)      cnt <= 16'h0000;
    else if (wr_cnt_l) cnt <= {temp, bus.wb_dat_i};
    else if (tick_clr) cnt <= 16'h0000;
    else if (tick)     cnt <= cnt + 16'd1;
  end

  // Compare register, loaded atomically from TEMP on the low-byte write
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)      cmp <= 16'hFFFF;
    else if (wr_cmp_l) cmp <= {temp, bus.wb_dat_i};
  end

  // TEMP: snapshots cnt high byte on CNT_L read, holds high byte for H writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                 temp <= 8'h00;
    else if (rd_cnt_l)            temp <= cnt[15:8];
    else if (wr_cnt_h || wr_cmp_h) temp <= bus.wb_dat_i;
  end

  // Control register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)     ctrl <= '0;
    else if (wr_ctrl) ctrl <= ctrl_t'(bus.wb_dat_i[3:0]);
  end

  // Status flags: a hardware set on the same edge as a clear wins
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmpf <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      cmpf <= hw_cmpf || (cmpf && !clr_cmpf);
      ovf  <= hw_ovf  || (ovf  && !clr_ovf);
    end
  end

  // Interrupt requests come straight off the flag registers
  assign bus.irq_o[0] = ctrl.cmpie & cmpf;
  generate
    if (ENA_OVF_IRQ != 0) begin : g_ovf_irq
      assign bus.irq_o[1] = ctrl.ovfie & ovf;
    end else begin : g_no_ovf_irq
      assign bus.irq_o[1] = 1'b0;
    end
  endgenerate

  // Read mux; compare bytes read back directly, unmapped addresses read 0
  always_comb begin
    bus.wb_dat_o = 8'h00;
    case (adr)
      ADR_CNT_L: bus.wb_dat_o = cnt[7:0];
      ADR_CNT_H: bus.wb_dat_o = temp;
      ADR_CMP_L: bus.wb_dat_o = cmp[7:0];
      ADR_CMP_H: bus.wb_dat_o = cmp[15:8];
      ADR_CTRL:  bus.wb_dat_o = ctrl_rd(ctrl);
      ADR_STAT:  bus.wb_dat_o = {6'b0, ovf, cmpf};
      default:   bus.wb_dat_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_wb_timer16.sv
// Directed bench for wb_timer16 (PRESC=4). Reads push expected data/irq into a
// queue; a negedge monitor pops and compares whenever the slave acks a read.
module tb_wb_timer16;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  always #5 clk = ~clk;

  wb_timer16_if bus();

  wb_timer16 #(.PRESC(4), .ENA_OVF_IRQ(1)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] dat;
    logic [1:0] irq;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %02h want %02h", nm, act, want);
  endtask

  // Monitor: every acked read is compared against the oldest expectation
  exp_t e;
  always @(negedge clk) begin
    if (bus.wb_ack_o === 1'b1 && bus.wb_we_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_read: got %02h want none", bus.wb_dat_o);
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".dat"}, bus.wb_dat_o, e.dat);
        check({e.name, ".irq"}, {6'b0, bus.irq_o}, {6'b0, e.irq});
      end
    end
  end

  // All drivers start #1 after a rising edge and finish #1 after the next one
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] d, input logic [1:0] irq,
                    input string nm);
    exp_t x;
    x.dat = d; x.irq = irq; x.name = nm;
    exp_q.push_back(x);
    bus.wb_adr_i = a; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_stb_i = 1'b0; bus.irq_ack_i = 2'b00;
    repeat (2) @(posedge clk);
    #1 wb_rst_i = 1'b0;

    // Reset state and map corners
    rd(ADR_CNT_L, 8'h00, 2'b00, "rst_cnt_l");
    rd(ADR_CNT_H, 8'h00, 2'b00, "rst_cnt_h");
    rd(ADR_CMP_L, 8'hFF, 2'b00, "rst_cmp_l");
    rd(ADR_CMP_H, 8'hFF, 2'b00, "rst_cmp_h");
    rd(ADR_CTRL,  8'h00, 2'b00, "rst_ctrl");
    rd(ADR_STAT,  8'h00, 2'b00, "rst_stat");
    wr(3'd6, 8'hFF);
    rd(3'd6, 8'h00, 2'b00, "adr6_zero");
    wr(ADR_CTRL, 8'hF0);
    rd(ADR_CTRL, 8'h00, 2'b00, "ctrl_hi_zero");

    // Compare match with CTC: CMP=3, CTRL=0x07 -> CMPF 16 clocks after enable
    wr(ADR_CMP_H, 8'h00);
    wr(ADR_CMP_L, 8'h03);
    wr(ADR_CTRL, 8'h07);
    idle(15);
    rd(ADR_STAT,  8'h00, 2'b00, "cmp_before");
    rd(ADR_STAT,  8'h01, 2'b01, "cmp_set");
    rd(ADR_CNT_L, 8'h00, 2'b01, "ctc_clear");
    bus.irq_ack_i = 2'b01;
    @(posedge clk); #1;
    bus.irq_ack_i = 2'b00;
    rd(ADR_STAT,  8'h00, 2'b00, "ack_clear");
    wr(ADR_CTRL, 8'h00);

    // Hardware CMPF set on the same edge as irq_ack: set wins
    wr(ADR_CNT_H, 8'h00);
    wr(ADR_CNT_L, 8'h00);
    wr(ADR_CTRL, 8'h07);
    idle(15);
    bus.irq_ack_i = 2'b01;
    @(posedge clk); #1;
    bus.irq_ack_i = 2'b00;
    rd(ADR_STAT, 8'h01, 2'b01, "set_beats_ack");
    wr(ADR_STAT, 8'h00);
    rd(ADR_STAT, 8'h01, 2'b01, "stat_w0_keep");
    wr(ADR_STAT, 8'h01);
    rd(ADR_STAT, 8'h00, 2'b00, "stat_w1_clr");
    wr(ADR_CTRL, 8'h00);

    // Overflow: CNT=0xFFFE, CTRL=0x09 -> OVF on second tick
    wr(ADR_CNT_H, 8'hFF);
    wr(ADR_CNT_L, 8'hFE);
    wr(ADR_CTRL, 8'h09);
    idle(7);
    rd(ADR_STAT,  8'h00, 2'b00, "ovf_before");
    rd(ADR_STAT,  8'h02, 2'b10, "ovf_set");
    rd(ADR_CNT_L, 8'h00, 2'b10, "ovf_cnt_l");
    rd(ADR_CNT_H, 8'h00, 2'b10, "ovf_cnt_h");
    wr(ADR_STAT, 8'h02);
    rd(ADR_STAT,  8'h00, 2'b00, "ovf_clr");
    // Keep counting with CMPIE on, no CTC: match at cnt=3 sets CMPF
    wr(ADR_CTRL, 8'h0B);
    idle(10);
    rd(ADR_STAT, 8'h01, 2'b01, "cmp_noctc");

    // Asynchronous reset pulse between edges, checked before the next edge
    #1;
    wb_rst_i = 1'b1;
    x.dat = 8'h00; x.irq = 2'b00; x.name = "async_rst_cnt";
    exp_q.push_back(x);
    bus.wb_adr_i = ADR_CNT_L; bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1;
    @(negedge clk); #2;
    bus.wb_stb_i = 1'b0;
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
    rd(ADR_CTRL,  8'h00, 2'b00, "post_rst_ctrl");
    rd(ADR_STAT,  8'h00, 2'b00, "post_rst_stat");
    rd(ADR_CMP_L, 8'hFF, 2'b00, "post_rst_cmp_l");
    rd(ADR_CMP_H, 8'hFF, 2'b00, "post_rst_cmp_h");
    idle(10);
    rd(ADR_CNT_L, 8'h00, 2'b00, "no_tick_after_rst");
    wr(ADR_CTRL, 8'h01);
    idle(8);
    rd(ADR_CNT_L, 8'h02, 2'b00, "resume_after_en");
    wr(ADR_CTRL, 8'h00);

    // Atomic read across a tick: 0x12FF reads back FF then 12
    wr(ADR_CNT_H, 8'h12);
    wr(ADR_CNT_L, 8'hFF);
    wr(ADR_CTRL, 8'h01);
    rd(ADR_CNT_L, 8'hFF, 2'b00, "atomic_lo");
    idle(3);
    rd(ADR_CNT_H, 8'h12, 2'b00, "atomic_hi");
    rd(ADR_CNT_L, 8'h00, 2'b00, "after_tick_lo");
    rd(ADR_CNT_H, 8'h13, 2'b00, "after_tick_hi");

    // CNT_L write on a tick edge wins; prescaler phase is unchanged
    wr(ADR_CNT_H, 8'h55);
    wr(ADR_CNT_L, 8'hAA);
    idle(2);
    wr(ADR_CNT_L, 8'h77);
    rd(ADR_CNT_L, 8'h77, 2'b00, "wr_beats_tick_lo");
    rd(ADR_CNT_H, 8'h55, 2'b00, "wr_beats_tick_hi");
    idle(1);
    rd(ADR_CNT_L, 8'h77, 2'b00, "presc_phase_hold");
    rd(ADR_CNT_L, 8'h78, 2'b00, "presc_phase_tick");

    idle(2);
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_total++;
      $display("FAIL %s: got no_ack want read", x.name);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
